// File: rtl/parity_check_rx.sv
// parity_check_rx: 8-bit serial receiver with even parity and stop-bit checking
module parity_check_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t          state_q, state_d;
    logic [1:0]      sync_q, sync_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      sh_q, sh_d;
    logic            par_q, par_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            perr_q, perr_d;
    logic            ferr_q, ferr_d;
    logic            rxs;
    logic            tick;

    assign rxs        = sync_q[1];
    assign tick       = (cnt_q == LAST);
    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;

    // Next-state, sampling and result capture; results land one cycle after the stop sample
    always_comb begin
        sync_d  = {sync_q[0], rxd};
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        data_d  = data_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxs) state_d = START;
            end
            START: if (cnt_q == HALF) begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = rxs ? IDLE : DATA;
            end
            DATA: if (tick) begin
                cnt_d = '0;
                sh_d  = {rxs, sh_q[7:1]};
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = PARITY;
            end
            PARITY: if (tick) begin
                cnt_d   = '0;
                par_d   = rxs;
                state_d = STOP;
            end
            STOP: if (tick) begin
                cnt_d   = '0;
                data_d  = sh_q;
                perr_d  = ^{sh_q, par_q};
                ferr_d  = !rxs;
                valid_d = 1'b1;
                state_d = rxs ? IDLE : BREAK;
            end
            BREAK: begin
                cnt_d = '0;
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; synchronizer resets to the idle-high line level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end
endmodule

// File: tb/tb_parity_check_rx.sv
// tb_parity_check_rx: table, directed and random frames against a frame-level model
`timescale 1ns/1ps
module tb_parity_check_rx;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] data;
    logic       valid, parity_err, frame_err;

    parity_check_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .rxd(rxd),
        .data(data), .valid(valid), .parity_err(parity_err), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [7:0] d; logic pe; logic fe;} exp_t;
    typedef struct {logic [7:0] d; logic p; logic stop; logic pe; logic fe;} vec_t;

    int         tests = 0;
    int         fails = 0;
    longint     cyc = 0;
    exp_t       expq[$];
    longint     stamps[$];
    exp_t       last = '0;
    vec_t       tab[8];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Frame monitor: every valid must match the oldest expected frame; outputs hold otherwise
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst_n) last = '0;
        if (valid) begin
            stamps.push_back(cyc);
            tests++;
            if (expq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_valid data=%h perr=%b ferr=%b required=no pulse", data, parity_err, frame_err);
            end else begin
                e = expq.pop_front();
                last = e;
                if ({data, parity_err, frame_err} !== e) begin
                    fails++;
                    $display("FAIL frame got data=%h perr=%b ferr=%b required data=%h perr=%b ferr=%b",
                             data, parity_err, frame_err, e.d, e.pe, e.fe);
                end
            end
        end else begin
            tests++;
            if ({data, parity_err, frame_err} !== last) begin
                fails++;
                $display("FAIL hold at cycle %0d got data=%h perr=%b ferr=%b required data=%h perr=%b ferr=%b",
                         cyc, data, parity_err, frame_err, last.d, last.pe, last.fe);
            end
        end
    end

    task automatic bits(input logic v, input int n);
        rxd = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic p, input logic stop);
        bits(1'b0, CPB);
        for (int i = 0; i < 8; i++) bits(d[i], CPB);
        bits(p, CPB);
        bits(stop, CPB);
    endtask

    task automatic expect_model(input logic [7:0] d, input logic p, input logic stop);
        exp_t e;
        e.d  = d;
        e.pe = (($countones(d) + int'(p)) % 2) != 0;
        e.fe = !stop;
        expq.push_back(e);
    endtask

    task automatic check_empty(input string name);
        tests++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL %s pending=%0d required=0", name, expq.size());
            expq.delete();
        end
    endtask

    task automatic check_reset(input string name);
        tests++;
        if ({data, valid, parity_err, frame_err} !== 11'h0) begin
            fails++;
            $display("FAIL %s got data=%h valid=%b perr=%b ferr=%b required all zero",
                     name, data, valid, parity_err, frame_err);
        end
    endtask

    initial begin
        int n0;
        logic [7:0] d;
        logic p, stop;
        tab[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
        tab[1] = '{8'h07, 1'b0, 1'b1, 1'b1, 1'b0};
        tab[2] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b0};
        tab[3] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
        tab[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0};
        tab[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
        tab[6] = '{8'hC3, 1'b0, 1'b0, 1'b0, 1'b1};
        tab[7] = '{8'h81, 1'b1, 1'b0, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        check_reset("reset_state");
        #2 rst_n = 1'b1;
        bits(1'b1, 2 * CPB);

        for (int k = 0; k < 8; k++) begin
            expq.push_back({tab[k].d, tab[k].pe, tab[k].fe});
            send(tab[k].d, tab[k].p, tab[k].stop);
            bits(1'b1, 2 * CPB);
            check_empty($sformatf("table_%0d", k));
        end

        expq.push_back({8'h3C, 1'b0, 1'b1});
        send(8'h3C, 1'b0, 1'b0);
        bits(1'b0, 40 * CPB);
        check_empty("break_frame");
        bits(1'b1, 2 * CPB);

        bits(1'b0, 4);
        bits(1'b1, 2 * CPB);
        expq.push_back({8'h5A, 1'b0, 1'b0});
        send(8'h5A, 1'b0, 1'b1);
        bits(1'b1, CPB);
        check_empty("glitch_then_5a");

        d = 8'hC6;
        bits(1'b0, CPB);
        for (int i = 0; i < 3; i++) bits(d[i], CPB);
        bits(d[3], CPB / 2);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset_mid_frame");
        rxd = 1'b1;
        #2 rst_n = 1'b1;
        bits(1'b1, 12 * CPB);
        check_empty("aborted_frame");
        expq.push_back({8'hFF, 1'b0, 1'b0});
        send(8'hFF, 1'b0, 1'b1);
        bits(1'b1, CPB);
        check_empty("after_reset_ff");

        n0 = stamps.size();
        expq.push_back({8'h00, 1'b0, 1'b0});
        expq.push_back({8'h01, 1'b0, 1'b0});
        expq.push_back({8'h80, 1'b0, 1'b0});
        send(8'h00, 1'b0, 1'b1);
        send(8'h01, 1'b1, 1'b1);
        send(8'h80, 1'b1, 1'b1);
        bits(1'b1, CPB);
        check_empty("back_to_back");
        tests++;
        if (stamps.size() - n0 != 3) begin
            fails++;
            $display("FAIL b2b_count got=%0d required=3", stamps.size() - n0);
        end else begin
            for (int i = 1; i < 3; i++) begin
                tests++;
                if (stamps[n0 + i] - stamps[n0 + i - 1] != longint'(11 * CPB)) begin
                    fails++;
                    $display("FAIL b2b_spacing_%0d got=%0d required=%0d", i,
                             stamps[n0 + i] - stamps[n0 + i - 1], 11 * CPB);
                end
            end
        end

        for (int k = 0; k < 30; k++) begin
            d = 8'($urandom);
            p = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 4) != 0);
            expect_model(d, p, stop);
            send(d, p, stop);
            bits(1'b1, stop ? int'($urandom_range(0, CPB)) : 2 * CPB);
        end
        bits(1'b1, 2 * CPB);
        check_empty("random_frames");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/parity_check_rx.md
PARITY_CHECK_RX -- requirements
Module: parity_check_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, giving clock cycles per serial bit period (legal range 4..65535; even values only).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset: asynchronous and active-low.
REQ-004 The block SHALL have port rxd, input, 1, the serial line, asynchronous to clk, idle high.
REQ-005 The block SHALL have port data, output, 8, the last received data byte.
REQ-006 The block SHALL have port valid, output, 1, a one-cycle pulse marking a completed frame.
REQ-007 The block SHALL have port parity_err, output, 1, the even-parity failure flag of the last frame.
REQ-008 The block SHALL have port frame_err, output, 1, the stop-bit failure flag of the last frame.

Function
REQ-009 The frame format SHALL be: start bit (0), d0..d7 LSB first, parity bit p, stop bit (1); 11 bit periods in total.
REQ-010 Parity SHALL be even: the frame is correct when the count of ones in d0..d7 plus p is even (p = XOR of d0..d7).
REQ-011 rxd SHALL pass through a two-flop synchronizer; all decisions below use the synchronized value rxs.
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-013 IDLE: rxs=0 SHALL enter START and clear the bit-period counter.
REQ-014 START: at counter = CLKS_PER_BIT/2-1 (mid start bit), rxs=0 SHALL enter DATA; rxs=1 is a false start and SHALL return to IDLE with no valid.
REQ-015 DATA: every CLKS_PER_BIT cycles after the mid-start sample, rxs SHALL be shifted in LSB first; after the 8th sample the FSM SHALL enter PARITY.
REQ-016 PARITY: one sample, CLKS_PER_BIT cycles after d7, SHALL be latched as p; then enter STOP.
REQ-017 STOP: one sample, CLKS_PER_BIT cycles after p; on the following cycle data, parity_err and frame_err SHALL be updated and valid SHALL pulse high for exactly one cycle.
REQ-018 Stop sample = 1: the FSM SHALL return to IDLE in the same cycle valid pulses.
REQ-019 Stop sample = 0: frame_err SHALL be set and the FSM SHALL enter BREAK.
REQ-020 BREAK SHALL hold until rxs=1, then enter IDLE; a continuous low line SHALL produce no further valid pulses.
REQ-021 valid SHALL pulse on every completed frame regardless of error flags; parity_err and frame_err qualify that frame only.
REQ-022 data, parity_err and frame_err SHALL hold their values between valid pulses.
REQ-023 Back-to-back frames (a start bit immediately after a stop bit) SHALL be received without loss.
REQ-024 The bit-period counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL reset to 0 on each sample point.

Reset
REQ-025 While rst_n=0: FSM = IDLE, counters and shift register = 0, synchronizer flops = 1, data = 8'h00, valid = 0, parity_err = 0, frame_err = 0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no valid pulse; after release the block SHALL wait in IDLE for a fresh falling edge.
REQ-027 Reset release SHALL take effect on the first clk rising edge after rst_n goes high.

Verification (CLKS_PER_BIT=16)
REQ-028 Frame 0xA5 with p=0 and stop=1 -> one valid pulse; data=8'hA5, parity_err=0, frame_err=0.
REQ-029 Frame 0x07 with p=0 (wrong) -> valid pulse; data=8'h07, parity_err=1, frame_err=0.
REQ-030 Frame 0x3C with p=0 and stop=0, line then held low 40 bit periods -> exactly one valid pulse with frame_err=1; no further valid until rxd returns high and a new frame is sent.
REQ-031 rxd low glitch of 4 cycles on an idle line -> no valid; the next good frame 0x5A is received correctly.
REQ-032 rst_n pulsed low during d3 of a frame -> no valid for that frame, outputs at reset values; the next frame 0xFF with p=0 -> data=8'hFF, no errors.
REQ-033 Frames 0x00 (p=0), 0x01 (p=1), 0x80 (p=1) sent back-to-back -> three valid pulses, each exactly 11*16 cycles apart, correct data, no errors.
